// File: rtl/uart_brg.sv
// Fractional baud-rate generator: divides Clk by Prescale/2^FRAC_W and emits
// one-cycle baud_clk ticks at 8x the UART bit rate.
module uart_brg #(
    parameter int PRE_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [PRE_W-1:0] Prescale,
    output logic             baud_clk
);
    localparam int INT_W = PRE_W - FRAC_W;

    logic [INT_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_run;
    logic              r_baud;

    logic              w_clamp;
    logic [INT_W-1:0]  w_int;
    logic [FRAC_W-1:0] w_frac;
    logic [FRAC_W-1:0] w_acc_base;
    logic [FRAC_W:0]   w_sum;
    logic [INT_W-1:0]  w_len_m1;

    // Divisors below 2 would leave no low cycle between ticks, so force 2.0.
    assign w_clamp    = (Prescale[PRE_W-1:FRAC_W] < INT_W'(2));
    assign w_int      = w_clamp ? INT_W'(2) : Prescale[PRE_W-1:FRAC_W];
    assign w_frac     = w_clamp ? '0 : Prescale[FRAC_W-1:0];

    // A fresh start always begins the fractional sequence from zero.
    assign w_acc_base = r_run ? r_acc : '0;
    assign w_sum      = {1'b0, w_acc_base} + {1'b0, w_frac};
    assign w_len_m1   = w_int + {{(INT_W-1){1'b0}}, w_sum[FRAC_W]} - INT_W'(1);

    // cnt holds cycles remaining in the period; the tick fires when it hits
    // zero and the next period is loaded on that same edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_run  <= 1'b0;
            r_baud <= 1'b0;
        end else if (!En) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_run  <= 1'b0;
            r_baud <= 1'b0;
        end else if (!r_run || r_cnt == '0) begin
            r_run  <= 1'b1;
            r_cnt  <= w_len_m1;
            r_acc  <= w_sum[FRAC_W-1:0];
            r_baud <= r_run;
        end else begin
            r_cnt  <= r_cnt - INT_W'(1);
            r_baud <= 1'b0;
        end
    end

    assign baud_clk = r_baud;

endmodule

// File: tb/tb_uart_brg.sv
// Bench for uart_brg: table of prescale cases, random prescales against an
// arithmetic period model, and hand-written enable/reset/retune sequences.
module tb_uart_brg;
    localparam int PRE_W  = 16;
    localparam int FRAC_W = 4;
    localparam int NFR    = 1 << FRAC_W;

    logic             Clk;
    logic             Rst;
    logic             En;
    logic [PRE_W-1:0] Prescale;
    logic             baud_clk;

    uart_brg #(.PRE_W(PRE_W), .FRAC_W(FRAC_W)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Prescale(Prescale), .baud_clk(baud_clk)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;   // 50 MHz

    int cyc = 0;
    int pq[$];
    int iv[$];
    int checks = 0;
    int failures = 0;

    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) if (baud_clk) pq.push_back(cyc);

    typedef struct {
        int  presc;
        int  npulse;
        int  min_i;
        int  max_i;
        int  win_sum;
        real rate;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Period k (k>=1) gets an extra cycle whenever the running fraction
    // k*F/2^FRAC_W crosses an integer.
    function automatic int exp_len(input int p, input int k);
        int i, f;
        i = p / NFR;
        f = p % NFR;
        if (i < 2) begin
            i = 2;
            f = 0;
        end
        return i + (k * f) / NFR - ((k - 1) * f) / NFR;
    endfunction

    task automatic stop_and_clear();
        @(negedge Clk); #1;
        En = 1'b0;
        @(negedge Clk); #1;
        pq.delete();
    endtask

    task automatic enable_at(output int e0);
        @(negedge Clk); #1;
        En = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk); #1;
        end
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (pq.size() < n && b < budget) begin
            @(negedge Clk); #1;
            b++;
        end
        chk({name, " pulse count"}, pq.size(), n);
    endtask

    task automatic build_iv(input int e0, input int n);
        int m, prev;
        iv.delete();
        m = (pq.size() < n) ? pq.size() : n;
        prev = e0;
        for (int k = 0; k < m; k++) begin
            iv.push_back(pq[k] - prev);
            prev = pq[k];
        end
    endtask

    task automatic check_train(input string name, input int p, input int e0, input int n);
        build_iv(e0, n);
        for (int k = 0; k < iv.size(); k++)
            chk({name, " interval"}, iv[k], exp_len(p, k + 1));
    endtask

    int e0, e1, mn, mx, ws, sz, p;
    real f_meas, err;
    int exp_mid[7];

    initial begin
        tbl[0] = '{presc: 868,   npulse: 200, min_i: 54,  max_i: 55,  win_sum: 868,   rate: 921600.0};
        tbl[1] = '{presc: 864,   npulse: 200, min_i: 54,  max_i: 54,  win_sum: 864,   rate: 921600.0};
        tbl[2] = '{presc: 10417, npulse: 33,  min_i: 651, max_i: 652, win_sum: 10417, rate: 76800.0};
        tbl[3] = '{presc: 16,    npulse: 40,  min_i: 2,   max_i: 2,   win_sum: 32,    rate: 25000000.0};
        tbl[4] = '{presc: 5,     npulse: 40,  min_i: 2,   max_i: 2,   win_sum: 32,    rate: 25000000.0};
        exp_mid = '{54, 54, 54, 55, 54, 54, 54};

        Rst = 1'b1;
        En = 1'b0;
        Prescale = 16'd868;
        wait_cycles(10);
        chk("reset baud_clk", int'(baud_clk), 0);
        Rst = 1'b0;
        pq.delete();
        wait_cycles(20);
        chk("idle after reset pulses", pq.size(), 0);

        // Table-driven prescale cases
        foreach (tbl[t]) begin
            stop_and_clear();
            Prescale = tbl[t].presc[PRE_W-1:0];
            enable_at(e0);
            wait_pulses(tbl[t].npulse, tbl[t].npulse * (tbl[t].max_i + 2) + 50,
                        $sformatf("p%0d", tbl[t].presc));
            check_train($sformatf("p%0d", tbl[t].presc), tbl[t].presc, e0, tbl[t].npulse);
            build_iv(e0, tbl[t].npulse);
            if (iv.size() > 1) begin
                mn = iv[0];
                mx = iv[0];
                foreach (iv[k]) begin
                    if (iv[k] < mn) mn = iv[k];
                    if (iv[k] > mx) mx = iv[k];
                end
                chk($sformatf("p%0d min", tbl[t].presc), mn, tbl[t].min_i);
                chk($sformatf("p%0d max", tbl[t].presc), mx, tbl[t].max_i);
                for (int s = 0; s + NFR <= iv.size(); s++) begin
                    ws = 0;
                    for (int j = s; j < s + NFR; j++) ws += iv[j];
                    chk($sformatf("p%0d window16 sum", tbl[t].presc), ws, tbl[t].win_sum);
                end
                sz = pq.size();
                f_meas = real'(sz - 1) * 50.0e6 / real'(pq[sz-1] - pq[0]);
                err = (f_meas - tbl[t].rate) / tbl[t].rate;
                if (err < 0.0) err = -err;
                chk($sformatf("p%0d rate within 0.5pct (err ppm %0d)", tbl[t].presc, int'(err * 1.0e6)),
                    int'(err <= 0.005), 1);
            end
        end

        // Random prescales against the period model
        for (int r = 0; r < 6; r++) begin
            stop_and_clear();
            p = $urandom_range(0, 1300);
            Prescale = p[PRE_W-1:0];
            enable_at(e0);
            wait_pulses(40, 40 * (p / NFR + 3) + 50, $sformatf("rand p%0d", p));
            check_train($sformatf("rand p%0d", p), p, e0, 40);
        end

        // Disable mid-period, then re-enable: fresh start from acc = 0
        stop_and_clear();
        Prescale = 16'd868;
        enable_at(e0);
        wait_pulses(3, 300, "pre-disable");
        wait_cycles(20);
        En = 1'b0;
        sz = pq.size();
        wait_cycles(500);
        chk("pulses while disabled", pq.size(), sz);
        chk("baud_clk while disabled", int'(baud_clk), 0);
        pq.delete();
        enable_at(e1);
        wait_pulses(8, 600, "re-enable");
        check_train("re-enable", 868, e1, 8);

        // Disable landing exactly on the pulse edge suppresses that pulse
        stop_and_clear();
        Prescale = 16'd864;
        enable_at(e0);
        while (cyc < e0 + 53) begin
            @(negedge Clk); #1;
        end
        En = 1'b0;
        @(negedge Clk); #1;
        chk("disable on pulse edge baud_clk", int'(baud_clk), 0);
        wait_cycles(100);
        chk("disable on pulse edge pulses", pq.size(), 0);

        // Async reset while baud_clk is high
        stop_and_clear();
        Prescale = 16'd868;
        enable_at(e0);
        sz = 0;
        while (!baud_clk && sz < 200) begin
            @(negedge Clk); #1;
            sz++;
        end
        chk("baud_clk high before reset", int'(baud_clk), 1);
        #2 Rst = 1'b1;
        #1 chk("async reset drops baud_clk", int'(baud_clk), 0);
        wait_cycles(3);
        pq.delete();
        Rst = 1'b0;
        e1 = cyc + 1;
        wait_pulses(6, 400, "after reset");
        check_train("after reset", 868, e1, 6);

        // Retune 868 -> 864 mid-period: current period finishes unchanged
        stop_and_clear();
        Prescale = 16'd868;
        enable_at(e0);
        wait_pulses(3, 300, "retune pre");
        wait_cycles(20);
        Prescale = 16'd864;
        wait_pulses(7, 500, "retune");
        build_iv(e0, 7);
        foreach (iv[k]) chk($sformatf("retune interval %0d", k + 1), iv[k], exp_mid[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
